// File: rtl/top_pkg.sv
// top_pkg: shared widths, y field offsets and the stage-1 result record
package top_pkg;

   localparam int W_A    = 12;
   localparam int W_B    = 20;
   localparam int W_C    = 22;
   localparam int W_D    = 19;
   localparam int W_E    = 21;
   localparam int W_Y    = 136;
   localparam int W_SUM  = 23;
   localparam int W_PROD = 31;
   localparam int W_ACC  = 32;
   localparam int W_CNT  = 16;

   localparam int OFF_ACC  = 104;
   localparam int OFF_SUM  = 81;
   localparam int OFF_XOR  = 61;
   localparam int OFF_AND  = 49;
   localparam int OFF_CNT  = 33;
   localparam int OFF_PROD = 2;
   localparam int OFF_CMP  = 1;
   localparam int OFF_PAR  = 0;

   typedef struct packed {
      logic [W_SUM-1:0]  sum;
      logic [W_B-1:0]    x;
      logic [W_A-1:0]    a;
      logic [W_PROD-1:0] prod;
      logic              cmp;
      logic              par;
   } stage_t;

endpackage

// File: rtl/top_acc.sv
// top_acc: 32-bit wrapping signed accumulator with synchronous clear
module top_acc
   import top_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [W_SUM-1:0] addend,
   output logic [W_ACC-1:0]        acc
);

   logic [W_ACC-1:0] acc_d, acc_q;

   // sign-extend the addend and let the sum wrap modulo 2^32
   always_comb acc_d = acc_q + {{(W_ACC - W_SUM){addend[W_SUM-1]}}, addend};

   // accumulator register, cleared by reset
   always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;

   assign acc = acc_q;

endmodule

// File: rtl/top_core.sv
// top_core: registered mixed-arithmetic datapath packing all results into y
module top_core
   import top_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic [W_A-1:0] wire0,
   input  logic [W_B-1:0] wire1,
   input  logic [W_C-1:0] wire2,
   input  logic [W_D-1:0] wire3,
   input  logic [W_E-1:0] wire4,
   output logic [W_Y-1:0] y
);

   stage_t           st_d, st_q;
   logic [W_CNT-1:0] cnt_d, cnt_q;
   logic [W_ACC-1:0] acc;

   // stage-1 results from the operands present at this edge
   always_comb begin
      st_d      = '0;
      st_d.sum  = {wire2[W_C-1], wire2} + {{2{wire4[W_E-1]}}, wire4};
      st_d.x    = wire1 ^ {1'b0, wire3};
      st_d.a    = wire0 & wire3[W_A-1:0];
      st_d.prod = {19'd0, wire0} * {12'd0, wire3};
      st_d.cmp  = $signed({wire2[W_C-1], wire2}) < $signed({{2{wire4[W_E-1]}}, wire4});
      st_d.par  = ^{wire0, wire1, wire2, wire3, wire4};
   end

   // free-running cycle counter, wraps at 16 bits
   always_comb cnt_d = cnt_q + 16'd1;

   // stage-1 and counter registers, all cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= '0;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   // the accumulator consumes the registered sum, so it trails the inputs by two edges
   top_acc u_acc (
      .clk    (clk),
      .rst    (rst),
      .addend (st_q.sum),
      .acc    (acc)
   );

   // pack the registered fields into the status word
   always_comb begin
      y                        = '0;
      y[OFF_ACC  +: W_ACC]     = acc;
      y[OFF_SUM  +: W_SUM]     = st_q.sum;
      y[OFF_XOR  +: W_B]       = st_q.x;
      y[OFF_AND  +: W_A]       = st_q.a;
      y[OFF_CNT  +: W_CNT]     = cnt_q;
      y[OFF_PROD +: W_PROD]    = st_q.prod;
      y[OFF_CMP]               = st_q.cmp;
      y[OFF_PAR]               = st_q.par;
   end

endmodule

// File: tb/tb_top_core.sv
// tb_top_core: table vectors, directed sequences and random stimulus against a reference model
module tb_top_core;
   import top_pkg::*;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [W_A-1:0] wire0 = '0;
   logic [W_B-1:0] wire1 = '0;
   logic [W_C-1:0] wire2 = '0;
   logic [W_D-1:0] wire3 = '0;
   logic [W_E-1:0] wire4 = '0;
   logic [W_Y-1:0] y;

   int checks = 0;
   int errors = 0;

   longint    m_sum, m_acc, m_prod;
   int        m_xor, m_and, m_cmp, m_par, m_cnt;

   top_core dut (
      .clk   (clk),
      .rst   (rst),
      .wire0 (wire0),
      .wire1 (wire1),
      .wire2 (wire2),
      .wire3 (wire3),
      .wire4 (wire4),
      .y     (y)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] w0;
      logic [19:0] w1;
      logic [21:0] w2;
      logic [18:0] w3;
      logic [20:0] w4;
      logic [22:0] sum;
      logic [19:0] x;
      logic [11:0] a;
      logic [30:0] p;
      logic        c;
      logic        par;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [W_Y-1:0] got, input logic [W_Y-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [W_Y-1:0] model_y();
      logic [W_Y-1:0] r;
      r = '0;
      r[OFF_ACC  +: 32] = m_acc[31:0];
      r[OFF_SUM  +: 23] = m_sum[22:0];
      r[OFF_XOR  +: 20] = m_xor[19:0];
      r[OFF_AND  +: 12] = m_and[11:0];
      r[OFF_CNT  +: 16] = m_cnt[15:0];
      r[OFF_PROD +: 31] = m_prod[30:0];
      r[OFF_CMP]        = m_cmp[0];
      r[OFF_PAR]        = m_par[0];
      return r;
   endfunction

   task automatic model_reset();
      m_sum = 0; m_acc = 0; m_prod = 0;
      m_xor = 0; m_and = 0; m_cmp = 0; m_par = 0; m_cnt = 0;
   endtask

   // one clock: the model applies the spec rules to the inputs held across the edge, then y is compared
   task automatic tick(input string name);
      longint c, e;
      @(posedge clk);
      if (rst) model_reset();
      else begin
         m_acc  = (m_acc + m_sum) & 64'hFFFF_FFFF;
         m_cnt  = (m_cnt + 1) % 65536;
         c      = longint'($signed(wire2));
         e      = longint'($signed(wire4));
         m_sum  = c + e;
         m_cmp  = (c < e) ? 1 : 0;
         m_xor  = int'(wire1) ^ int'(wire3);
         m_and  = int'(wire0) & int'(wire3) & 'hFFF;
         m_prod = longint'(wire0) * longint'(wire3);
         m_par  = $countones({wire0, wire1, wire2, wire3, wire4}) % 2;
      end
      #1;
      chk(name, y, model_y());
   endtask

   task automatic drive(input logic [11:0] a, input logic [19:0] b, input logic [21:0] c,
                        input logic [18:0] d, input logic [20:0] e);
      wire0 = a; wire1 = b; wire2 = c; wire3 = d; wire4 = e;
   endtask

   task automatic drive_rand();
      drive(12'($urandom), 20'($urandom), 22'($urandom), 19'($urandom), 21'($urandom));
   endtask

   initial begin
      model_reset();
      tbl[0] = '{12'h000, 20'h00000, 22'h000000, 19'h00000, 21'h000000, 23'h000000, 20'h00000, 12'h000, 31'h00000000, 1'b0, 1'b0};
      tbl[1] = '{12'h000, 20'h00000, 22'h3FFFFF, 19'h00000, 21'h1FFFFF, 23'h7FFFFE, 20'h00000, 12'h000, 31'h00000000, 1'b0, 1'b1};
      tbl[2] = '{12'hFFF, 20'h00000, 22'h000000, 19'h7FFFF, 21'h000000, 23'h000000, 20'h7FFFF, 12'hFFF, 31'h7FF7F001, 1'b0, 1'b1};
      tbl[3] = '{12'h000, 20'h00000, 22'h000001, 19'h00000, 21'h000002, 23'h000003, 20'h00000, 12'h000, 31'h00000000, 1'b1, 1'b0};
      tbl[4] = '{12'h000, 20'h00001, 22'h000000, 19'h00000, 21'h000000, 23'h000000, 20'h00001, 12'h000, 31'h00000000, 1'b0, 1'b1};
      tbl[5] = '{12'h000, 20'h00000, 22'h200000, 19'h00000, 21'h0FFFFF, 23'h6FFFFF, 20'h00000, 12'h000, 31'h00000000, 1'b1, 1'b1};
      tbl[6] = '{12'h000, 20'h00000, 22'h1FFFFF, 19'h00000, 21'h100000, 23'h0FFFFF, 20'h00000, 12'h000, 31'h00000000, 1'b0, 1'b0};
      tbl[7] = '{12'h000, 20'hFFFFF, 22'h000000, 19'h7FFFF, 21'h000000, 23'h000000, 20'h80000, 12'h000, 31'h00000000, 1'b0, 1'b1};
      tbl[8] = '{12'hABC, 20'h00000, 22'h000000, 19'h00123, 21'h000000, 23'h000000, 20'h00123, 12'h020, 31'h000C33B4, 1'b0, 1'b1};

      // reset held for two edges with busy inputs
      rst = 1'b1;
      drive(12'h5A5, 20'hABCDE, 22'h123456, 19'h7FFFF, 21'h1ABCDE);
      for (int i = 0; i < 2; i++) begin
         tick("reset_model");
         chk("reset_zero", y, '0);
      end

      // idle after reset: only the counter moves
      rst = 1'b0;
      drive('0, '0, '0, '0, '0);
      for (int i = 0; i < 3; i++) tick("idle_model");
      chk("idle_cnt3", y, W_Y'(3) << OFF_CNT);

      // both signed operands at -1: sum -2 appears, then lands in acc one edge later
      drive('0, '0, 22'h3FFFFF, '0, 21'h1FFFFF);
      tick("neg_edge1");
      chk("neg_sum", W_Y'(y[OFF_SUM +: W_SUM]), W_Y'(23'h7FFFFE));
      chk("neg_cmp", W_Y'(y[OFF_CMP]), W_Y'(1'b0));
      tick("neg_edge2");
      chk("neg_acc", W_Y'(y[OFF_ACC +: W_ACC]), W_Y'(32'hFFFFFFFE));

      // hand-derived single-edge vectors for the stage-1 fields
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3, tbl[i].w4);
         tick($sformatf("tbl%0d_model", i));
         chk($sformatf("tbl%0d_sum", i),  W_Y'(y[OFF_SUM  +: W_SUM]),  W_Y'(tbl[i].sum));
         chk($sformatf("tbl%0d_xor", i),  W_Y'(y[OFF_XOR  +: W_B]),    W_Y'(tbl[i].x));
         chk($sformatf("tbl%0d_and", i),  W_Y'(y[OFF_AND  +: W_A]),    W_Y'(tbl[i].a));
         chk($sformatf("tbl%0d_prod", i), W_Y'(y[OFF_PROD +: W_PROD]), W_Y'(tbl[i].p));
         chk($sformatf("tbl%0d_cmp", i),  W_Y'(y[OFF_CMP]),            W_Y'(tbl[i].c));
         chk($sformatf("tbl%0d_par", i),  W_Y'(y[OFF_PAR]),            W_Y'(tbl[i].par));
      end

      // reset in the middle of random traffic
      for (int i = 0; i < 10; i++) begin
         drive_rand();
         tick("pre_rst_rand");
      end
      rst = 1'b1;
      drive_rand();
      tick("mid_rst_model");
      chk("mid_rst_zero", y, '0);
      rst = 1'b0;
      drive_rand();
      tick("post_rst_model");
      chk("post_rst_cnt1", W_Y'(y[OFF_CNT +: W_CNT]), W_Y'(16'd1));

      // long random run against the model, with occasional resets
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         drive_rand();
         tick("rand_model");
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
